// File: rtl/sd_dat_tx.sv
// sd_dat_tx: serial block writer for SD DAT0 in 1-bit bus mode.
// Frame: start bit (0), payload MSB-first, CRC16 (x^16+x^12+x^5+1, zero init)
// MSB-first, end bit (1). One-byte holding register with ready/valid fill.
// Every output is a flop. Each one is loaded from the next-state values, so it
// shows the state of the current cycle.
module sd_dat_tx #(
   parameter int BLOCK_BYTES = 512,
   parameter int CNT_W       = 13
) (
   input  logic       iclk,
   input  logic       irst_n,
   input  logic       istart,
   input  logic [7:0] ibyte,
   input  logic       ibyte_valid,
   output logic       obyte_ready,
   output logic       odat,
   output logic       odat_oe,
   output logic       obusy,
   output logic       odone,
   output logic       ounderrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_CRC, S_END
   } state_t;

   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(8 * BLOCK_BYTES - 1);
   localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(15);
   localparam logic [15:0]      POLY      = 16'h1021;

   state_t           state_q, state_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [7:0]       shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      crc_q, crc_d;
   logic             odat_q, odat_d;
   logic             oe_q, oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             und_q, und_d;
   logic             ready_q, ready_d;
   logic             consume;
   logic             abort;
   logic             handshake;

   assign handshake = ibyte_valid & ready_q;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      consume = 1'b0;
      abort   = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            crc_d = '0;
            if (istart) state_d = S_START;
         end
         S_START: begin
            cnt_d = '0;
            crc_d = '0;
            if (hold_full_q) begin
               shift_d = hold_q;
               consume = 1'b1;
               state_d = S_DATA;
            end else begin
               abort = 1'b1;
            end
         end
         S_DATA: begin
            // CRC absorbs the bit currently on the line
            crc_d   = {crc_q[14:0], 1'b0} ^ ((shift_q[7] ^ crc_q[15]) ? POLY : 16'h0000);
            shift_d = {shift_q[6:0], 1'b0};
            if (cnt_q == DATA_LAST) begin
               cnt_d   = '0;
               state_d = S_CRC;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q[2:0] == 3'd7) begin
                  if (hold_full_q) begin
                     shift_d = hold_q;
                     consume = 1'b1;
                  end else begin
                     abort = 1'b1;
                  end
               end
            end
         end
         S_CRC: begin
            crc_d = {crc_q[14:0], 1'b0};
            if (cnt_q == CRC_LAST) begin
               cnt_d   = '0;
               state_d = S_END;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_END: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Underrun: drop the frame and clear the datapath
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         crc_d   = '0;
         shift_d = '0;
      end

      // Holding register never fills and drains in the same cycle (ready = !full)
      hold_d      = handshake ? ibyte : hold_q;
      hold_full_d = handshake ? 1'b1 : (consume ? 1'b0 : hold_full_q);
      ready_d     = ~hold_full_d;

      case (state_d)
         S_START: odat_d = 1'b0;
         S_DATA:  odat_d = shift_d[7];
         S_CRC:   odat_d = crc_d[15];
         default: odat_d = 1'b1;
      endcase
      oe_d   = (state_d != S_IDLE);
      busy_d = (state_d != S_IDLE);
      und_d  = abort;
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         crc_q       <= '0;
         odat_q      <= 1'b1;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         und_q       <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         crc_q       <= crc_d;
         odat_q      <= odat_d;
         oe_q        <= oe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         und_q       <= und_d;
         ready_q     <= ready_d;
      end
   end

   assign obyte_ready = ready_q;
   assign odat        = odat_q;
   assign odat_oe     = oe_q;
   assign obusy       = busy_q;
   assign odone       = done_q;
   assign ounderrun   = und_q;

endmodule

// File: tb/tb_sd_dat_tx.sv
// Bench for sd_dat_tx: three instances (1, 4 and 512 byte blocks), one selected
// at a time. Expected line bits are queued when a frame is set up and popped by
// the monitor while odat_oe is high.
module tb_sd_dat_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic [7:0] bytev = 8'h00;
   logic [1:0] sel = 2'd0;
   logic [2:0] sel_oh;
   logic [2:0] rdy, dat, oe, bsy, dne, und;

   always #5 clk = ~clk;

   assign sel_oh = 3'b001 << sel;

   sd_dat_tx #(.BLOCK_BYTES(1), .CNT_W(4)) u_b1 (
      .iclk(clk), .irst_n(rst_n), .istart(start & sel_oh[0]), .ibyte(bytev),
      .ibyte_valid(valid & sel_oh[0]), .obyte_ready(rdy[0]), .odat(dat[0]),
      .odat_oe(oe[0]), .obusy(bsy[0]), .odone(dne[0]), .ounderrun(und[0]));

   sd_dat_tx #(.BLOCK_BYTES(4), .CNT_W(6)) u_b4 (
      .iclk(clk), .irst_n(rst_n), .istart(start & sel_oh[1]), .ibyte(bytev),
      .ibyte_valid(valid & sel_oh[1]), .obyte_ready(rdy[1]), .odat(dat[1]),
      .odat_oe(oe[1]), .obusy(bsy[1]), .odone(dne[1]), .ounderrun(und[1]));

   sd_dat_tx #(.BLOCK_BYTES(512), .CNT_W(13)) u_b512 (
      .iclk(clk), .irst_n(rst_n), .istart(start & sel_oh[2]), .ibyte(bytev),
      .ibyte_valid(valid & sel_oh[2]), .obyte_ready(rdy[2]), .odat(dat[2]),
      .odat_oe(oe[2]), .obusy(bsy[2]), .odone(dne[2]), .ounderrun(und[2]));

   int vectors = 0;
   int errors  = 0;

   logic       exp_q[$];
   logic [7:0] payload[$];

   int cyc = 0, oe_cnt = 0, done_cnt = 0, und_cnt = 0, hs_cnt = 0;
   int last_oe_cyc = 0, done_cyc = 0, und_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Monitor: scoreboard pop on every driven line bit, plus event counters
   always @(negedge clk) begin
      logic e;
      cyc++;
      if (rst_n) begin
         if (oe[sel]) begin
            oe_cnt++;
            last_oe_cyc = cyc;
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $error("FAIL extra_bit observed=%0b expected=none", dat[sel]);
            end else begin
               e = exp_q.pop_front();
               chk("odat_bit", {31'd0, dat[sel]}, {31'd0, e});
            end
         end
         if (dne[sel]) begin done_cnt++; done_cyc = cyc; end
         if (und[sel]) begin und_cnt++; und_cyc = cyc; end
         if (valid && rdy[sel]) hs_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present a byte and hold it until the DUT takes it
   task automatic push_byte(input logic [7:0] b);
      logic r;
      bit   ok;
      ok    = 1'b0;
      bytev = b;
      valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         r = rdy[sel];
         @(posedge clk);
         if (r) begin ok = 1'b1; break; end
      end
      #1;
      valid = 1'b0;
      chk("byte_accepted", {31'd0, ok}, 32'd1);
   endtask

   // Byte-at-a-time CRC16-CCITT over the payload queue, zero init
   function automatic logic [15:0] crc_model();
      logic [15:0] c;
      c = 16'h0000;
      foreach (payload[j]) begin
         c = c ^ {payload[j], 8'h00};
         for (int k = 0; k < 8; k++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   task automatic expect_bytes(input int nbytes);
      logic [7:0] b;
      exp_q.push_back(1'b0);
      for (int j = 0; j < nbytes; j++) begin
         b = payload[j];
         for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
      end
   endtask

   task automatic expect_frame(input logic [15:0] crc);
      expect_bytes(payload.size());
      for (int i = 15; i >= 0; i--) exp_q.push_back(crc[i]);
      exp_q.push_back(1'b1);
   endtask

   // Bounded wait for odone or ounderrun, then a few idle cycles for stray pulses
   task automatic wait_end(input string tag, input int budget, input int d0, input int u0);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt != d0 || und_cnt != u0) begin seen = 1'b1; break; end
      end
      #1;
      if (!seen) begin
         vectors++;
         errors++;
         $error("FAIL %s_timeout observed=no_end expected=end_within_%0d", tag, budget);
      end
      repeat (4) step();
   endtask

   task automatic frame_checks(input string tag, input int o0, input int d0, input int u0,
                               input int n_oe, input int n_done, input int n_und);
      chk({tag, "_oe_cycles"}, oe_cnt - o0, n_oe);
      chk({tag, "_done"}, done_cnt - d0, n_done);
      chk({tag, "_underrun"}, und_cnt - u0, n_und);
      chk({tag, "_bits_left"}, exp_q.size(), 0);
      chk({tag, "_busy_after"}, {31'd0, bsy[sel]}, 32'd0);
   endtask

   initial begin
      int         o0, d0, u0, h0;
      logic [15:0] c;

      // Reset state of every instance
      repeat (3) step();
      for (int k = 0; k < 3; k++) begin
         chk("rst_odat", {31'd0, dat[k]}, 32'd1);
         chk("rst_oe", {31'd0, oe[k]}, 32'd0);
         chk("rst_busy", {31'd0, bsy[k]}, 32'd0);
         chk("rst_done", {31'd0, dne[k]}, 32'd0);
         chk("rst_und", {31'd0, und[k]}, 32'd0);
         chk("rst_ready", {31'd0, rdy[k]}, 32'd1);
      end
      rst_n = 1'b1;
      repeat (2) step();

      // 1-byte block of 0x00: CRC 0x0000, 26 enabled cycles, odone right after end bit
      sel = 2'd0;
      payload = {8'h00};
      expect_frame(16'h0000);
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt;
      push_byte(8'h00);
      pulse_start();
      wait_end("b1_zero", 60, d0, u0);
      frame_checks("b1_zero", o0, d0, u0, 26, 1, 0);
      chk("b1_zero_done_timing", done_cyc, last_oe_cyc + 1);

      // 1-byte block of 0x01: CRC 0x1021
      payload = {8'h01};
      expect_frame(16'h1021);
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt;
      push_byte(8'h01);
      pulse_start();
      wait_end("b1_one", 60, d0, u0);
      frame_checks("b1_one", o0, d0, u0, 26, 1, 0);

      // istart with empty holding register: one start bit then underrun
      exp_q.push_back(1'b0);
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt;
      pulse_start();
      wait_end("b1_empty", 20, d0, u0);
      frame_checks("b1_empty", o0, d0, u0, 1, 0, 1);
      chk("b1_empty_und_timing", und_cyc, last_oe_cyc + 1);

      // istart pulses during DATA and CRC must not disturb the frame
      payload = {8'hA5};
      expect_frame(crc_model());
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt;
      push_byte(8'hA5);
      pulse_start();
      repeat (4) step();
      pulse_start();
      repeat (10) step();
      pulse_start();
      wait_end("b1_ignore", 60, d0, u0);
      frame_checks("b1_ignore", o0, d0, u0, 26, 1, 0);

      // 4-byte block, third byte withheld: abort after byte 2
      sel = 2'd1;
      payload = {8'h11, 8'h22, 8'h33, 8'h44};
      expect_bytes(2);
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt;
      push_byte(8'h11);
      pulse_start();
      push_byte(8'h22);
      wait_end("b4_abort", 80, d0, u0);
      frame_checks("b4_abort", o0, d0, u0, 17, 0, 1);
      chk("b4_abort_und_timing", und_cyc, last_oe_cyc + 1);

      // Recovery frame on the same instance
      payload = {8'hC3, 8'h5A, 8'h0F, 8'hF0};
      expect_frame(crc_model());
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt;
      push_byte(8'hC3);
      pulse_start();
      push_byte(8'h5A);
      push_byte(8'h0F);
      push_byte(8'hF0);
      wait_end("b4_full", 120, d0, u0);
      frame_checks("b4_full", o0, d0, u0, 50, 1, 0);

      // 512 bytes of 0xFF with ibyte_valid held high: CRC 0x7FA1
      sel = 2'd2;
      payload.delete();
      for (int j = 0; j < 512; j++) payload.push_back(8'hFF);
      expect_frame(16'h7FA1);
      bytev = 8'hFF;
      valid = 1'b1;
      repeat (3) step();
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt; h0 = hs_cnt;
      pulse_start();
      wait_end("b512", 4300, d0, u0);
      valid = 1'b0;
      frame_checks("b512", o0, d0, u0, 4114, 1, 0);
      chk("b512_handshakes", hs_cnt - h0, 512);

      // Asynchronous reset in the middle of DATA
      sel = 2'd1;
      payload = {8'h96, 8'h69, 8'h3C, 8'hC3};
      expect_frame(crc_model());
      push_byte(8'h96);
      pulse_start();
      push_byte(8'h69);
      repeat (3) step();
      chk("mid_busy_before_rst", {31'd0, bsy[1]}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_odat", {31'd0, dat[1]}, 32'd1);
      chk("async_rst_oe", {31'd0, oe[1]}, 32'd0);
      chk("async_rst_busy", {31'd0, bsy[1]}, 32'd0);
      chk("async_rst_ready", {31'd0, rdy[1]}, 32'd1);
      exp_q.delete();
      step();
      #3;
      rst_n = 1'b1;
      o0 = oe_cnt; d0 = done_cnt; u0 = und_cnt;
      repeat (20) step();
      chk("post_rst_oe", oe_cnt - o0, 0);
      chk("post_rst_done", done_cnt - d0, 0);
      chk("post_rst_und", und_cnt - u0, 0);
      chk("post_rst_ready", {31'd0, rdy[1]}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
